// File: rtl/reg_rr_arbiter.sv
// reg_rr_arbiter: round-robin sharing of one register-interface target between
// NumReq requesters. One transaction is in flight at a time; an optional
// timeout completes a stalled transaction with an error response.

package reg_rr_arbiter_pkg;

   // Default regbus request: the requester holds valid and all fields stable until ready.
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   // Default regbus response: ready completes the transfer in the same cycle.
   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

endpackage

module reg_rr_arbiter #(
   parameter int unsigned NumReq        = 4,
   parameter int unsigned TimeoutCycles = 0,
   parameter type         reg_req_t     = reg_rr_arbiter_pkg::reg_req_t,
   parameter type         reg_rsp_t     = reg_rr_arbiter_pkg::reg_rsp_t
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  reg_req_t req_i [NumReq],
   output reg_rsp_t rsp_o [NumReq],
   output reg_req_t reg_req_o,
   input  reg_rsp_t reg_rsp_i
);

   localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int unsigned TmoW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

   typedef enum logic {
      IDLE,
      BUSY
   } state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

   logic            pick_found;
   logic [IdxW-1:0] pick_idx;
   logic [IdxW-1:0] cand_idx;
   int unsigned     cand;
   logic [IdxW-1:0] rr_next;
   logic            tmo_hit;
   reg_req_t        gnt_req;

   // Pointer for the next round once the current grant completes; wraps to 0 for NumReq=1.
   assign rr_next = IdxW'((32'(gnt_idx_q) + 32'd1) % NumReq);

   // Timeout fires on BUSY cycle number TimeoutCycles (the counter starts at 0 on cycle 1).
   assign tmo_hit = (TimeoutCycles != 0) && (tmo_cnt_q == TmoW'(TimeoutCycles - 1));

   // Round-robin search: first valid requester at or above rr_ptr, wrapping around.
   always_comb begin
      // NOTE: every signal written here gets a default before any branch, so no latch is inferred.
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         cand     = (32'(rr_ptr_q) + k) % NumReq;
         cand_idx = IdxW'(cand);
         if (!pick_found && req_i[cand_idx].valid) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Next-state logic and output muxing; outputs depend only on registered state and inputs.
   always_comb begin
      state_d   = state_q;
      gnt_idx_d = gnt_idx_q;
      rr_ptr_d  = rr_ptr_q;
      tmo_cnt_d = tmo_cnt_q;
      reg_req_o = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         rsp_o[i] = '0;
      end
      gnt_req = req_i[gnt_idx_q];

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d   = BUSY;
               gnt_idx_d = pick_idx;
               tmo_cnt_d = '0;
            end
         end
         BUSY: begin
            reg_req_o        = gnt_req;
            rsp_o[gnt_idx_q] = reg_rsp_i;
            if (!gnt_req.valid) begin
               // Requester withdrew: drop the grant without advancing the pointer.
               state_d = IDLE;
            end else if (reg_rsp_i.ready) begin
               state_d  = IDLE;
               rr_ptr_d = rr_next;
            end else if (tmo_hit) begin
               // Hide the request from the target and complete it locally with an error.
               reg_req_o.valid        = 1'b0;
               rsp_o[gnt_idx_q]       = '0;
               rsp_o[gnt_idx_q].error = 1'b1;
               rsp_o[gnt_idx_q].ready = 1'b1;
               state_d                = IDLE;
               rr_ptr_d               = rr_next;
            end else if (tmo_cnt_q != '1) begin
               tmo_cnt_d = tmo_cnt_q + TmoW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      if (rst_i) begin
         state_q   <= IDLE;
         gnt_idx_q <= '0;
         rr_ptr_q  <= '0;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_idx_q <= gnt_idx_d;
         rr_ptr_q  <= rr_ptr_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Testbench for reg_rr_arbiter: directed stimulus with a response scoreboard.
// dut uses TimeoutCycles=5, dut2 uses TimeoutCycles=2 for the ready/timeout race.

module tb_reg_rr_arbiter;
   import reg_rr_arbiter_pkg::*;

   localparam int N = 4;

   typedef struct {
      int          port;
      logic [31:0] rdata;
      logic        error;
   } exp_t;

   logic     clk = 1'b0;
   logic     rst;

   reg_req_t req  [N];
   reg_rsp_t rsp  [N];
   reg_req_t fwd;
   reg_rsp_t tgt;

   reg_req_t req2 [N];
   reg_rsp_t rsp2 [N];
   reg_req_t fwd2;
   reg_rsp_t tgt2;

   exp_t exp_q[$];
   exp_t exp2_q[$];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit fair_chk = 1'b0;
   int last_rdy [N];

   always #5 clk = ~clk;

   reg_rr_arbiter #(.NumReq(N), .TimeoutCycles(5)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req),
      .rsp_o    (rsp),
      .reg_req_o(fwd),
      .reg_rsp_i(tgt)
   );

   reg_rr_arbiter #(.NumReq(N), .TimeoutCycles(2)) dut2 (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req2),
      .rsp_o    (rsp2),
      .reg_req_o(fwd2),
      .reg_rsp_i(tgt2)
   );

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic [31:0] addr, input logic wr, input logic [31:0] wd);
      req[p].addr  = addr;
      req[p].write = wr;
      req[p].wdata = wd;
      req[p].wstrb = 4'hF;
      req[p].valid = 1'b1;
   endtask

   function automatic reg_req_t mk_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
      reg_req_t r;
      r.addr  = addr;
      r.write = wr;
      r.wdata = wd;
      r.wstrb = 4'hF;
      r.valid = 1'b1;
      return r;
   endfunction

   // Monitor: pops the scoreboard whenever a requester sees ready.
   always @(negedge clk) begin
      int   nz;
      int   p;
      exp_t e;
      cyc++;

      nz = 0;
      p  = -1;
      for (int i = 0; i < N; i++) begin
         if (rsp[i] != '0) nz++;
         if (rsp[i].ready) p = i;
      end
      if (nz > 0) check("rsp_single_port", 96'(nz), 96'(1));
      if (p >= 0) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: port %0d got ready, expected no response", p);
         end else begin
            e = exp_q.pop_front();
            check("rsp_port", 96'(p), 96'(e.port));
            check("rsp_rdata", 96'(rsp[p].rdata), 96'(e.rdata));
            check("rsp_error", 96'(rsp[p].error), 96'(e.error));
            if (fair_chk) begin
               if (last_rdy[p] >= 0) check("fair_period", 96'(cyc - last_rdy[p]), 96'(8));
               last_rdy[p] = cyc;
            end
         end
      end

      nz = 0;
      p  = -1;
      for (int i = 0; i < N; i++) begin
         if (rsp2[i] != '0) nz++;
         if (rsp2[i].ready) p = i;
      end
      if (nz > 0) check("rsp2_single_port", 96'(nz), 96'(1));
      if (p >= 0) begin
         if (exp2_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp2_unexpected: port %0d got ready, expected no response", p);
         end else begin
            e = exp2_q.pop_front();
            check("rsp2_port", 96'(p), 96'(e.port));
            check("rsp2_rdata", 96'(rsp2[p].rdata), 96'(e.rdata));
            check("rsp2_error", 96'(rsp2[p].error), 96'(e.error));
         end
      end
   end

   initial begin
      reg_req_t e1;
      reg_req_t ew;

      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         req[i]      = '0;
         req2[i]     = '0;
         last_rdy[i] = -1;
      end
      tgt  = '0;
      tgt2 = '0;

      // Reset state: every output zero.
      tick();
      tick();
      @(negedge clk);
      check("rst_fwd", 96'(fwd), 96'(0));
      check("rst_fwd2", 96'(fwd2), 96'(0));
      for (int i = 0; i < N; i++) check("rst_rsp", 96'(rsp[i]), 96'(0));
      rst = 1'b0;
      tick();

      // Single requester on port 2, zero-wait target.
      e1 = mk_req(32'h10, 1'b1, 32'hA5A5_0001);
      tgt.ready = 1'b1; tgt.rdata = 32'h0000_1111; tgt.error = 1'b0;
      set_req(2, 32'h10, 1'b1, 32'hA5A5_0001);
      exp_q.push_back('{2, 32'h0000_1111, 1'b0});
      @(negedge clk);
      check("t1_idle_valid", 96'(fwd.valid), 96'(0));
      tick();
      @(negedge clk);
      check("t1_fwd", 96'(fwd), 96'(e1));
      check("t1_ready_latency", 96'(rsp[2].ready), 96'(1));
      tick();
      req[2].valid = 1'b0;

      // Pointer now 3: ports 0 and 3 compete, 3 wins; then all four round-robin 0,1,2,3,0,...
      tgt.rdata = 32'h0F0F_0000;
      set_req(0, 32'h20, 1'b0, 32'h0);
      set_req(3, 32'h30, 1'b0, 32'h0);
      exp_q.push_back('{3, 32'h0F0F_0000, 1'b0});
      tick();
      tick();
      set_req(1, 32'h24, 1'b1, 32'h11);
      set_req(2, 32'h28, 1'b1, 32'h22);
      set_req(3, 32'h2C, 1'b1, 32'h33);
      fair_chk = 1'b1;
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < N; p++) exp_q.push_back('{p, 32'h0F0F_0000, 1'b0});
      end
      repeat (16) tick();
      for (int i = 0; i < N; i++) req[i].valid = 1'b0;
      fair_chk = 1'b0;

      // Wait states: ready held low for 3 BUSY cycles, then error response on cycle 4.
      ew = mk_req(32'h44, 1'b0, 32'h0);
      tgt.ready = 1'b0; tgt.rdata = 32'h0; tgt.error = 1'b0;
      set_req(1, 32'h44, 1'b0, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (k == 4) begin
            tgt.ready = 1'b1; tgt.rdata = 32'hDEAD_BEEF; tgt.error = 1'b1;
            exp_q.push_back('{1, 32'hDEAD_BEEF, 1'b1});
         end
         @(negedge clk);
         check("ws_fwd_stable", 96'(fwd), 96'(ew));
      end
      tick();
      req[1].valid = 1'b0;
      tgt.ready = 1'b0; tgt.error = 1'b0;

      // Timeout on port 3: target never ready, forced error on BUSY cycle 5.
      tgt.rdata = 32'h5555_5555;
      set_req(3, 32'h50, 1'b1, 32'h77);
      exp_q.push_back('{3, 32'h0, 1'b1});
      for (int k = 1; k <= 5; k++) begin
         tick();
         @(negedge clk);
         check("to_fwd_valid", 96'(fwd.valid), 96'(k < 5));
      end
      tick();
      @(negedge clk);
      check("to_idle_next", 96'(fwd.valid), 96'(0));
      tick();
      req[3].valid = 1'b0;
      tick();

      // Abort: port 2 drops valid in BUSY; pointer stays 0 so port 1 beats port 3.
      tgt.rdata = 32'h0;
      set_req(2, 32'h60, 1'b1, 32'h66);
      tick();
      @(negedge clk);
      check("ab_fwd_valid", 96'(fwd.valid), 96'(1));
      tick();
      req[2].valid = 1'b0;
      @(negedge clk);
      check("ab_fwd_drop", 96'(fwd.valid), 96'(0));
      tick();
      set_req(1, 32'h64, 1'b0, 32'h0);
      set_req(3, 32'h68, 1'b0, 32'h0);
      tgt.ready = 1'b1; tgt.rdata = 32'h0000_0A0A;
      exp_q.push_back('{1, 32'h0000_0A0A, 1'b0});
      exp_q.push_back('{3, 32'h0000_0A0A, 1'b0});
      tick();
      tick();
      req[1].valid = 1'b0;
      tick();
      tick();
      req[3].valid = 1'b0;

      // Port 2 completes, leaving the pointer at 3.
      tgt.rdata = 32'h0000_2222;
      set_req(2, 32'h70, 1'b1, 32'h99);
      exp_q.push_back('{2, 32'h0000_2222, 1'b0});
      tick();
      tick();
      req[2].valid = 1'b0;

      // Reset during BUSY: outputs zero next cycle, pointer back to 0 so port 0 beats port 3.
      tgt.ready = 1'b0;
      set_req(0, 32'h74, 1'b0, 32'h0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("rm_busy_fwd", 96'(fwd.valid), 96'(1));
      tick();
      rst = 1'b0;
      set_req(3, 32'h78, 1'b0, 32'h0);
      tgt.ready = 1'b1; tgt.rdata = 32'h0000_3333;
      exp_q.push_back('{0, 32'h0000_3333, 1'b0});
      exp_q.push_back('{3, 32'h0000_3333, 1'b0});
      @(negedge clk);
      check("rm_fwd_zero", 96'(fwd), 96'(0));
      for (int i = 0; i < N; i++) check("rm_rsp_zero", 96'(rsp[i]), 96'(0));
      tick();
      tick();
      req[0].valid = 1'b0;
      tick();
      tick();
      req[3].valid = 1'b0;
      tgt.ready = 1'b0;

      // dut2 (TimeoutCycles=2): ready on BUSY cycle 2 beats the timeout.
      req2[0].addr = 32'h80; req2[0].write = 1'b0; req2[0].wdata = 32'h0;
      req2[0].wstrb = 4'hF; req2[0].valid = 1'b1;
      tgt2.ready = 1'b0; tgt2.rdata = 32'h0; tgt2.error = 1'b0;
      tick();
      tick();
      tgt2.ready = 1'b1; tgt2.rdata = 32'h0000_1234; tgt2.error = 1'b0;
      exp2_q.push_back('{0, 32'h0000_1234, 1'b0});
      @(negedge clk);
      check("co_fwd_valid", 96'(fwd2.valid), 96'(1));
      tick();
      req2[0].valid = 1'b0;
      tgt2.ready = 1'b0; tgt2.rdata = 32'h0000_9999;

      // dut2: no ready at all, timeout error on BUSY cycle 2.
      req2[1].addr = 32'h84; req2[1].write = 1'b1; req2[1].wdata = 32'h5;
      req2[1].wstrb = 4'hF; req2[1].valid = 1'b1;
      exp2_q.push_back('{1, 32'h0, 1'b1});
      tick();
      @(negedge clk);
      check("to2_fwd_c1", 96'(fwd2.valid), 96'(1));
      tick();
      @(negedge clk);
      check("to2_fwd_c2", 96'(fwd2.valid), 96'(0));
      tick();
      req2[1].valid = 1'b0;

      repeat (3) tick();
      check("sb_drained", 96'(exp_q.size()), 96'(0));
      check("sb2_drained", 96'(exp2_q.size()), 96'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
